// File: rtl/uart_frame_checker_if.sv
// Receive-path bundle between the baud sampler/front end (master) and the frame checker (slave).
// Latency: none, wires only; no backpressure, the consumer must take every frame_valid pulse.
interface uart_frame_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  start_det;
    logic                  sample_tick;
    logic                  rx_bit;
    logic [2:0]            parity_mode;
    logic                  clear_counts;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  frame_valid;
    logic                  parity_error;
    logic                  framing_error;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  perr_count;
    logic [CNT_WIDTH-1:0]  ferr_count;

    modport master (
        output start_det, sample_tick, rx_bit, parity_mode, clear_counts,
        input  data_out, frame_valid, parity_error, framing_error, busy, perr_count, ferr_count
    );

    modport slave (
        input  start_det, sample_tick, rx_bit, parity_mode, clear_counts,
        output data_out, frame_valid, parity_error, framing_error, busy, perr_count, ferr_count
    );
endinterface

// File: rtl/uart_frame_checker.sv
// UART frame checker: deserialises LSB-first data, checks parity/stop bits, keeps saturating error counts.
// Latency: frame_valid 1 clk after the last stop tick; no backpressure, results are one-cycle pulses.
module uart_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_checker_if.slave    bus
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    state_e                state_q, state_d;
    logic [2:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  acc_q, acc_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  perr_pend_q, perr_pend_d;
    logic                  ferr_pend_q, ferr_pend_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  framing_error_q, framing_error_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  perr_cnt_q, perr_cnt_d;
    logic [CNT_WIDTH-1:0]  ferr_cnt_q, ferr_cnt_d;

    logic has_parity;
    logic exp_parity;
    logic ferr_now;
    logic perr_inc;
    logic ferr_inc;

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        shift_d         = shift_q;
        acc_d           = acc_q;
        bit_cnt_d       = bit_cnt_q;
        stop_cnt_d      = stop_cnt_q;
        perr_pend_d     = perr_pend_q;
        ferr_pend_d     = ferr_pend_q;
        data_out_d      = data_out_q;
        frame_valid_d   = 1'b0;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;
        has_parity      = (mode_q >= 3'd1) && (mode_q <= 3'd4);
        ferr_now        = ferr_pend_q | ~bus.rx_bit;

        case (mode_q)
            3'd1:    exp_parity = acc_q;
            3'd2:    exp_parity = ~acc_q;
            3'd3:    exp_parity = 1'b1;
            default: exp_parity = 1'b0;
        endcase

        // A new start always wins, including over a coincident tick or a frame in flight.
        if (bus.start_det) begin
            state_d     = DATA;
            mode_d      = bus.parity_mode;
            shift_d     = '0;
            acc_d       = 1'b0;
            bit_cnt_d   = '0;
            stop_cnt_d  = 1'b0;
            perr_pend_d = 1'b0;
            ferr_pend_d = 1'b0;
        end else if (bus.sample_tick) begin
            case (state_q)
                DATA: begin
                    shift_d   = {bus.rx_bit, shift_q[DATA_WIDTH-1:1]};
                    acc_d     = acc_q ^ bus.rx_bit;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        state_d    = has_parity ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
                PARITY: begin
                    perr_pend_d = (bus.rx_bit != exp_parity);
                    state_d     = STOP;
                    stop_cnt_d  = 1'b0;
                end
                STOP: begin
                    ferr_pend_d = ferr_now;
                    stop_cnt_d  = stop_cnt_q + 1'b1;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d         = IDLE;
                        frame_valid_d   = 1'b1;
                        data_out_d      = shift_q;
                        parity_error_d  = perr_pend_q;
                        framing_error_d = ferr_now;
                    end
                end
                default: ;
            endcase
        end

        busy_d   = (state_d != IDLE);
        perr_inc = frame_valid_d & parity_error_d;
        ferr_inc = frame_valid_d & framing_error_d;

        // Clear and increment together leave the counter at one.
        perr_cnt_d = perr_cnt_q;
        if (bus.clear_counts) begin
            perr_cnt_d = perr_inc ? CNT_WIDTH'(1) : '0;
        end else if (perr_inc && (perr_cnt_q != '1)) begin
            perr_cnt_d = perr_cnt_q + CNT_WIDTH'(1);
        end

        ferr_cnt_d = ferr_cnt_q;
        if (bus.clear_counts) begin
            ferr_cnt_d = ferr_inc ? CNT_WIDTH'(1) : '0;
        end else if (ferr_inc && (ferr_cnt_q != '1)) begin
            ferr_cnt_d = ferr_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            mode_q          <= '0;
            shift_q         <= '0;
            acc_q           <= 1'b0;
            bit_cnt_q       <= '0;
            stop_cnt_q      <= 1'b0;
            perr_pend_q     <= 1'b0;
            ferr_pend_q     <= 1'b0;
            data_out_q      <= '0;
            frame_valid_q   <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
            perr_cnt_q      <= '0;
            ferr_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            shift_q         <= shift_d;
            acc_q           <= acc_d;
            bit_cnt_q       <= bit_cnt_d;
            stop_cnt_q      <= stop_cnt_d;
            perr_pend_q     <= perr_pend_d;
            ferr_pend_q     <= ferr_pend_d;
            data_out_q      <= data_out_d;
            frame_valid_q   <= frame_valid_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            busy_q          <= busy_d;
            perr_cnt_q      <= perr_cnt_d;
            ferr_cnt_q      <= ferr_cnt_d;
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.parity_error  = parity_error_q;
    assign bus.framing_error = framing_error_q;
    assign bus.busy          = busy_q;
    assign bus.perr_count    = perr_cnt_q;
    assign bus.ferr_count    = ferr_cnt_q;
endmodule

// File: tb/tb_uart_frame_checker.sv
// Bench for uart_frame_checker: two configurations (8N1/8-bit counters and 7-bit/2-stop/2-bit counters)
// driven with randomized frames; expectations come from frame-level arithmetic on what was sent.
module tb_uart_frame_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_w[2];
    logic       start_det_w[2];
    logic       sample_tick_w[2];
    logic       rx_bit_w[2];
    logic [2:0] mode_w[2];
    logic       clear_w[2];
    logic [8:0] dout_w[2];
    logic       fv_w[2];
    logic       perr_w[2];
    logic       ferr_w[2];
    logic       busy_w[2];
    logic [7:0] pcnt_w[2];
    logic [7:0] fcnt_w[2];

    uart_frame_checker_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) if_a ();
    uart_frame_checker_if #(.DATA_WIDTH(7), .CNT_WIDTH(2)) if_b ();

    uart_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
        .clk (clk), .rst (rst_w[0]), .bus (if_a.slave)
    );
    uart_frame_checker #(.DATA_WIDTH(7), .STOP_BITS(2), .CNT_WIDTH(2)) dut_b (
        .clk (clk), .rst (rst_w[1]), .bus (if_b.slave)
    );

    assign if_a.start_det    = start_det_w[0];
    assign if_a.sample_tick  = sample_tick_w[0];
    assign if_a.rx_bit       = rx_bit_w[0];
    assign if_a.parity_mode  = mode_w[0];
    assign if_a.clear_counts = clear_w[0];
    assign if_b.start_det    = start_det_w[1];
    assign if_b.sample_tick  = sample_tick_w[1];
    assign if_b.rx_bit       = rx_bit_w[1];
    assign if_b.parity_mode  = mode_w[1];
    assign if_b.clear_counts = clear_w[1];

    assign dout_w[0] = {1'b0, if_a.data_out};
    assign dout_w[1] = {2'b0, if_b.data_out};
    assign fv_w[0]   = if_a.frame_valid;
    assign fv_w[1]   = if_b.frame_valid;
    assign perr_w[0] = if_a.parity_error;
    assign perr_w[1] = if_b.parity_error;
    assign ferr_w[0] = if_a.framing_error;
    assign ferr_w[1] = if_b.framing_error;
    assign busy_w[0] = if_a.busy;
    assign busy_w[1] = if_b.busy;
    assign pcnt_w[0] = if_a.perr_count;
    assign pcnt_w[1] = {6'b0, if_b.perr_count};
    assign fcnt_w[0] = if_a.ferr_count;
    assign fcnt_w[1] = {6'b0, if_b.ferr_count};

    int checks   = 0;
    int failures = 0;
    int fv_cnt[2];
    int exp_frames[2];
    int exp_pcnt[2];
    int exp_fcnt[2];
    int exp_dout[2];

    always @(negedge clk) begin
        if (fv_w[0] === 1'b1) fv_cnt[0]++;
        if (fv_w[1] === 1'b1) fv_cnt[1]++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic tick(input int w, input bit b);
        sample_tick_w[w] = 1'b1;
        rx_bit_w[w]      = b;
        mode_w[w]        = 3'($urandom);
        step();
        sample_tick_w[w] = 1'b0;
        rx_bit_w[w]      = 1'($urandom);
    endtask

    function automatic int sat_next(input int cur, input bit inc, input bit clr, input int cmax);
        if (clr) return inc ? 1 : 0;
        if (inc) return (cur < cmax) ? cur + 1 : cmax;
        return cur;
    endfunction

    // stops: bit j is the value sent for stop bit j; abort_after >= 0 stops after that many data ticks.
    task automatic send_frame(input int w, input int data, input int mode, input bit pbit,
                              input int stops, input bit clr, input int abort_after);
        int dw       = (w == 0) ? 8 : 7;
        int sb       = (w == 0) ? 1 : 2;
        int cmax     = (w == 0) ? 255 : 3;
        int mask     = (1 << dw) - 1;
        bit has_par  = (mode >= 1) && (mode <= 4);
        int ones;
        bit pexp;
        bit perr;
        bit ferr;

        if (busy_w[w] == 1'b0) tick(w, 1'($urandom));
        check_eq("idle_tick_ignored", fv_cnt[w], exp_frames[w]);

        start_det_w[w]   = 1'b1;
        mode_w[w]        = 3'(mode);
        sample_tick_w[w] = 1'($urandom);
        rx_bit_w[w]      = 1'($urandom);
        step();
        start_det_w[w]   = 1'b0;
        sample_tick_w[w] = 1'b0;
        check_eq("busy_after_start", busy_w[w], 1);

        for (int i = 0; i < dw; i++) begin
            if (i == abort_after) return;
            gap();
            tick(w, 1'((data >> i) & 1));
        end
        if (has_par) begin
            gap();
            tick(w, pbit);
        end
        for (int j = 0; j < sb; j++) begin
            gap();
            if (j == sb - 1) clear_w[w] = clr;
            tick(w, 1'((stops >> j) & 1));
            clear_w[w] = 1'b0;
            if (j < sb - 1) check_eq("busy_between_stops", busy_w[w], 1);
        end

        ones = $countones(data & mask);
        case (mode)
            1:       pexp = 1'(ones % 2);
            2:       pexp = 1'(1 - ones % 2);
            3:       pexp = 1'b1;
            default: pexp = 1'b0;
        endcase
        perr = has_par && (pbit != pexp);
        ferr = ((stops & ((1 << sb) - 1)) != ((1 << sb) - 1));
        exp_pcnt[w] = sat_next(exp_pcnt[w], perr, clr, cmax);
        exp_fcnt[w] = sat_next(exp_fcnt[w], ferr, clr, cmax);
        exp_dout[w] = data & mask;
        exp_frames[w]++;

        check_eq("frame_valid_latency", fv_w[w], 1);
        check_eq("data_out", dout_w[w], exp_dout[w]);
        check_eq("parity_error", perr_w[w], perr);
        check_eq("framing_error", ferr_w[w], ferr);
        check_eq("busy_after_stop", busy_w[w], 0);
        check_eq("perr_count", pcnt_w[w], exp_pcnt[w]);
        check_eq("ferr_count", fcnt_w[w], exp_fcnt[w]);
        step();
        check_eq("frame_valid_single", fv_w[w], 0);
        check_eq("data_out_hold", dout_w[w], exp_dout[w]);
        check_eq("frame_count", fv_cnt[w], exp_frames[w]);
    endtask

    task automatic clear_alone(input int w);
        clear_w[w] = 1'b1;
        step();
        clear_w[w] = 1'b0;
        exp_pcnt[w] = 0;
        exp_fcnt[w] = 0;
        check_eq("clear_perr", pcnt_w[w], 0);
        check_eq("clear_ferr", fcnt_w[w], 0);
    endtask

    task automatic check_zero_outputs(input int w);
        check_eq("rst_data_out", dout_w[w], 0);
        check_eq("rst_frame_valid", fv_w[w], 0);
        check_eq("rst_parity_error", perr_w[w], 0);
        check_eq("rst_framing_error", ferr_w[w], 0);
        check_eq("rst_busy", busy_w[w], 0);
        check_eq("rst_perr_count", pcnt_w[w], 0);
        check_eq("rst_ferr_count", fcnt_w[w], 0);
    endtask

    task automatic random_frames(input int w, input int n);
        int dw = (w == 0) ? 8 : 7;
        int stops;
        int abort_at;
        for (int k = 0; k < n; k++) begin
            stops    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : 3;
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, dw - 1)) : -1;
            send_frame(w, int'($urandom_range(0, 511)), int'($urandom_range(0, 7)),
                       1'($urandom), stops, ($urandom_range(0, 7) == 0), abort_at);
        end
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            rst_w[w] = 1'b1; start_det_w[w] = 1'b0; sample_tick_w[w] = 1'b0;
            rx_bit_w[w] = 1'b1; mode_w[w] = 3'd0; clear_w[w] = 1'b0;
            fv_cnt[w] = 0; exp_frames[w] = 0; exp_pcnt[w] = 0; exp_fcnt[w] = 0; exp_dout[w] = 0;
        end
        step();
        step();
        rst_w[0] = 1'b0;
        rst_w[1] = 1'b0;
        check_zero_outputs(0);
        check_zero_outputs(1);

        send_frame(0, 'hA5, 1, 1'b0, 1, 1'b0, -1);
        send_frame(0, 'h01, 2, 1'b1, 1, 1'b0, -1);
        send_frame(0, 'h3B, 3, 1'b0, 1, 1'b0, -1);
        send_frame(0, 'h3B, 4, 1'b0, 1, 1'b0, -1);
        send_frame(0, 'hC3, 6, 1'b0, 1, 1'b0, -1);
        send_frame(0, 'hFF, 1, 1'b0, 1, 1'b0, 4);
        send_frame(0, 'h5A, 1, 1'b0, 1, 1'b0, -1);
        random_frames(0, 40);

        send_frame(0, 'h77, 1, 1'b0, 1, 1'b0, 3);
        rst_w[0] = 1'b1;
        step();
        rst_w[0] = 1'b0;
        exp_pcnt[0] = 0;
        exp_fcnt[0] = 0;
        check_zero_outputs(0);
        for (int i = 0; i < 8; i++) tick(0, 1'b1);
        step();
        check_eq("no_frame_after_rst", fv_cnt[0], exp_frames[0]);
        check_eq("idle_after_rst", busy_w[0], 0);

        send_frame(1, 'h3C, 0, 1'b0, 'b01, 1'b0, -1);
        for (int i = 0; i < 5; i++) send_frame(1, 0, 2, 1'b0, 3, 1'b0, -1);
        send_frame(1, 0, 2, 1'b0, 3, 1'b1, -1);
        clear_alone(1);
        random_frames(1, 40);
        clear_alone(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end
endmodule
